// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// slave: the cache itself; master: the request unit plus memory controller.
interface icache_direct_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with single-word fills.
// Hits are served combinationally; a miss latches the word address and
// runs one iREN/iwait read, then the request hits on a later cycle.
// Optional feature: define ICACHE_STATS_EN to add hit_count/miss_count.
module icache_direct #(
  parameter int unsigned SETS = 16
) (
  input logic             CLK,
  input logic             nRST,
  icache_direct_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {StIdle, StFetch} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fill_addr_q, fill_addr_d;
  logic               valid_q [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS];
  logic [31:0]        data_q  [SETS];

  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit;
  logic               miss;
  logic               fill_we;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = fill_addr_q[IDX_W+1:2];
  assign fill_tag = fill_addr_q[31:IDX_W+2];

  // Lookup only counts as a hit while idle; fills never forward data early.
  assign hit  = (state_q == StIdle) && bus.imemREN && valid_q[req_idx] &&
                (tag_q[req_idx] == req_tag);
  assign miss = (state_q == StIdle) && bus.imemREN && !hit;

  // State and latched fill address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  // Next-state and outputs; the fill uses only fill_addr, never the live request.
  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_we      = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          bus.ihit     = 1'b1;
          bus.imemload = data_q[req_idx];
        end else if (miss) begin
          fill_addr_d = {bus.imemaddr[31:2], 2'b00};
          state_d     = StFetch;
        end
      end
      StFetch: begin
        bus.iREN  = 1'b1;
        bus.iaddr = fill_addr_q;
        if (!bus.iwait) begin
          fill_we = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame storage; a fill overwrites whatever the frame held.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(SETS); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (fill_we) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx]   <= fill_tag;
      data_q[fill_idx]  <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed cases from the test plan, then random
// fetches checked by a scoreboard against an abstract cache model.
module tb_icache_direct;
  localparam int unsigned SETS = 16;

  logic CLK;
  logic nRST;
  icache_direct_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_direct #(.SETS(SETS)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=event-missing exp=event", name);
  endtask

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: directed values, or random wait with model data.
  logic        resp_en = 1'b0;
  logic        rnd_wait = 1'b1;
  logic        dir_iwait;
  logic [31:0] dir_iload;
  always @(posedge CLK) rnd_wait <= ($urandom_range(0, 1) == 0);
  assign bus.iwait = resp_en ? rnd_wait : dir_iwait;
  assign bus.iload = resp_en ? (rnd_wait ? 32'hDEAD_BEEF : mem_word(bus.iaddr)) : dir_iload;

  // Scoreboard
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
  } exp_t;
  exp_t exp_q[$];
  logic mon_en = 1'b0;
  int   fetch_cycles = 0;

  // Monitor: compare every ihit against the oldest outstanding request.
  always @(negedge CLK) begin
    if (mon_en && nRST) begin
      if (bus.iREN) begin
        fetch_cycles++;
        if (exp_q.size() == 0) fail("spurious_iren");
        else check("fill_iaddr", bus.iaddr, {exp_q[0].addr[31:2], 2'b00});
      end
      if (bus.ihit) begin
        if (exp_q.size() == 0) begin
          fail("spurious_ihit");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hit_data", bus.imemload, e.data);
          check("hit_or_miss", {31'd0, fetch_cycles == 0}, {31'd0, e.hit});
        end
        fetch_cycles = 0;
      end
    end
  end

  // Abstract model: which word address each frame holds.
  bit          m_valid [SETS];
  logic [31:0] m_word  [SETS];
  int          exp_hits;
  int          exp_misses;

  task automatic neg();
    @(negedge CLK);
  endtask
  task automatic pos();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    bus.imemaddr = '0;
    dir_iwait = 1'b1;
    dir_iload = '0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Reset state
    neg();
    check("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    check("rst_imemload", bus.imemload, 32'd0);
    check("rst_iren", {31'd0, bus.iREN}, 32'd0);
    check("rst_iaddr", bus.iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    pos();

    // Cold miss
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40; dir_iwait = 1'b0; dir_iload = 32'h2002_0001;
    neg(); check("cold_c0_ihit", {31'd0, bus.ihit}, 32'd0); pos();
    neg();
    check("cold_c1_iren", {31'd0, bus.iREN}, 32'd1);
    check("cold_c1_iaddr", bus.iaddr, 32'h40);
    check("cold_c1_ihit", {31'd0, bus.ihit}, 32'd0);
    pos();
    neg();
    check("cold_c2_ihit", {31'd0, bus.ihit}, 32'd1);
    check("cold_c2_data", bus.imemload, 32'h2002_0001);
    pos();

    // Warm hit, then offset bits ignored
    neg();
    check("warm_ihit", {31'd0, bus.ihit}, 32'd1);
    check("warm_iren", {31'd0, bus.iREN}, 32'd0);
    pos();
    bus.imemaddr = 32'h43;
    neg();
    check("offset_ihit", {31'd0, bus.ihit}, 32'd1);
    check("offset_data", bus.imemload, 32'h2002_0001);
    pos();
    bus.imemREN = 1'b0;
    neg();
    check("idle_ihit", {31'd0, bus.ihit}, 32'd0);
    check("idle_imemload", bus.imemload, 32'd0);
`ifdef ICACHE_STATS_EN
    check("stats_hits", hit_count, 32'd3);
    check("stats_misses1", miss_count, 32'd1);
`endif
    pos();

    // Conflict: 0x440 evicts 0x40
    bus.imemREN = 1'b1; bus.imemaddr = 32'h440; dir_iload = 32'h1111_1111;
    neg(); check("conf_miss", {31'd0, bus.ihit}, 32'd0); pos();
    neg(); check("conf_iaddr", bus.iaddr, 32'h440); pos();
    neg(); check("conf_data", bus.imemload, 32'h1111_1111); pos();

    // 0x40 misses again; slow memory with the address moving to 0x80
    bus.imemaddr = 32'h40; dir_iwait = 1'b1;
    neg(); check("evict_miss", {31'd0, bus.ihit}, 32'd0); pos();
    bus.imemaddr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      neg();
      check("slow_iren", {31'd0, bus.iREN}, 32'd1);
      check("slow_iaddr", bus.iaddr, 32'h40);
`ifdef ICACHE_STATS_EN
      if (i == 0) check("stats_misses3", miss_count, 32'd3);
`endif
      pos();
    end
    dir_iwait = 1'b0; dir_iload = 32'h2222_2222;
    neg(); check("slow_last_iaddr", bus.iaddr, 32'h40); pos();
    bus.imemaddr = 32'h40; dir_iwait = 1'b1;
    neg();
    check("slow_frame_hit", {31'd0, bus.ihit}, 32'd1);
    check("slow_frame_data", bus.imemload, 32'h2222_2222);
    pos();
    bus.imemaddr = 32'h80;
    neg(); check("after_slow_80_miss", {31'd0, bus.ihit}, 32'd0); pos();

    // Reset mid-fill
    neg();
    check("fill80_iaddr", bus.iaddr, 32'h80);
    #1 nRST = 1'b0;
    #1;
    check("midrst_iren", {31'd0, bus.iREN}, 32'd0);
    check("midrst_iaddr", bus.iaddr, 32'd0);
    pos();
    nRST = 1'b1;
    bus.imemaddr = 32'h40;
    neg(); check("postrst_miss", {31'd0, bus.ihit}, 32'd0); pos();
    neg(); check("postrst_iaddr", bus.iaddr, 32'h40); pos();

    // Random phase from a clean reset
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    #2 nRST = 1'b1;
    resp_en = 1'b1;
    mon_en = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    for (int i = 0; i < int'(SETS); i++) begin
      m_valid[i] = 1'b0;
      m_word[i] = '0;
    end
    pos();
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int          idx;
      bit          h;
      int          wait_cyc;
      if ($urandom_range(0, 3) == 0) begin
        bus.imemREN = 1'b0;
        bus.imemaddr = $urandom;
        pos();
      end
      a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      idx = int'(a[5:2]);
      h = m_valid[idx] && (m_word[idx] == {a[31:2], 2'b00});
      exp_q.push_back('{addr: a, data: mem_word(a), hit: h});
      if (h) exp_hits++;
      else exp_misses++;
      m_valid[idx] = 1'b1;
      m_word[idx] = {a[31:2], 2'b00};
      bus.imemREN = 1'b1;
      bus.imemaddr = a;
      wait_cyc = 0;
      forever begin
        neg();
        if (bus.ihit) break;
        wait_cyc++;
        if (wait_cyc > 100) begin
          fail("ihit_timeout");
          break;
        end
      end
      pos();
    end
    bus.imemREN = 1'b0;
    neg();
    check("queue_drained", exp_q.size(), 32'd0);
`ifdef ICACHE_STATS_EN
    check("rnd_hit_count", hit_count, exp_hits);
    check("rnd_miss_count", miss_count, exp_misses);
`endif
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
